// File: rtl/stage_sequencer_if.sv
// Command and burn-parameter bundle between the flight controller and the stage sequencer.
// The sequencer connects to the slave modport; the controller side uses master.
interface stage_sequencer_if #(
   parameter int N = 64
);
   logic         start;
   logic         abort;
   logic         ignition_end;
   logic         engine_resetb;
   logic [N-1:0] specificImpulse;
   logic [N-1:0] initialWeight;
   logic [N-1:0] propellantWeight;
   logic [N-1:0] burntime;
   logic [2:0]   stage_state;
   logic         stage_sep;
   logic         mission_done;
   logic         aborted;

   modport master (
      output start, abort, ignition_end,
      input  engine_resetb, specificImpulse, initialWeight, propellantWeight,
             burntime, stage_state, stage_sep, mission_done, aborted
   );

   modport slave (
      input  start, abort, ignition_end,
      output engine_resetb, specificImpulse, initialWeight, propellantWeight,
             burntime, stage_state, stage_sep, mission_done, aborted
   );
endinterface

// File: rtl/stage_sequencer.sv
// Four-burn launch sequencer: steps LOAD/BURN/SEP/COAST per burn and presents the
// Isp, initial mass, propellant mass and burn time of the current burn to the integrator.
module stage_sequencer #(
   parameter N                   = 64,
   parameter SPECIFICIMPULSE_1   = 363,
   parameter SPECIFICIMPULSE_2   = 421,
   parameter SPECIFICIMPULSE_3   = 421,
   parameter WEIGHT_PROPELLANT_1 = 2077000,
   parameter WEIGHT_PROPELLANT_2 = 456100,
   parameter WEIGHT_PROPELLANT_3 = 39136,
   parameter WEIGHT_PROPELLANT_4 = 83864,
   parameter BURNTIME_1          = 48,
   parameter BURNTIME_2          = 360,
   parameter BURNTIME_3          = 165,
   parameter BURNTIME_4          = 335,
   parameter WEIGHT_STAGE_1      = 137000,
   parameter WEIGHT_STAGE_2      = 40100,
   parameter WEIGHT_STAGE_3      = 15200,
   parameter LM                  = 15103,
   parameter CMSM                = 11900,
   parameter SEP_CYCLES          = 4,
   parameter COAST_CYCLES        = 8
) (
   input logic                clk,
   input logic                resetb,
   stage_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_BURN, S_SEP, S_COAST, S_DONE, S_ABORT
   } state_t;

   localparam logic [N-1:0] P1 = N'(WEIGHT_PROPELLANT_1);
   localparam logic [N-1:0] P2 = N'(WEIGHT_PROPELLANT_2);
   localparam logic [N-1:0] P3 = N'(WEIGHT_PROPELLANT_3);
   localparam logic [N-1:0] P4 = N'(WEIGHT_PROPELLANT_4);
   localparam logic [N-1:0] D1 = N'(WEIGHT_STAGE_1);
   localparam logic [N-1:0] D2 = N'(WEIGHT_STAGE_2);
   localparam logic [N-1:0] D3 = N'(WEIGHT_STAGE_3);
   localparam logic [N-1:0] PAYLOAD = N'(LM) + N'(CMSM);

   // Stage 3 stays attached through burn 4, so its dry mass is in every sum.
   localparam logic [N-1:0] IW4 = P4 + D3 + PAYLOAD;
   localparam logic [N-1:0] IW3 = P3 + IW4;
   localparam logic [N-1:0] IW2 = P2 + D2 + IW3;
   localparam logic [N-1:0] IW1 = P1 + D1 + IW2;

   localparam logic [31:0] SEP_LOAD   = (SEP_CYCLES   == 0) ? 32'd0 : 32'(SEP_CYCLES - 1);
   localparam logic [31:0] COAST_LOAD = (COAST_CYCLES == 0) ? 32'd0 : 32'(COAST_CYCLES - 1);

   state_t       state_q, state_d;
   logic [2:0]   k_q, k_d;
   logic [31:0]  cnt_q, cnt_d;
   logic [N-1:0] isp_q, isp_d;
   logic [N-1:0] iw_q, iw_d;
   logic [N-1:0] pw_q, pw_d;
   logic [N-1:0] bt_q, bt_d;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q <= S_IDLE;
         k_q     <= 3'd0;
         cnt_q   <= 32'd0;
         isp_q   <= '0;
         iw_q    <= '0;
         pw_q    <= '0;
         bt_q    <= N'(1);
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         isp_q   <= isp_d;
         iw_q    <= iw_d;
         pw_q    <= pw_d;
         bt_q    <= bt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      isp_d   = isp_q;
      iw_d    = iw_q;
      pw_d    = pw_q;
      bt_d    = bt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               k_d     = 3'd1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_BURN;
         S_BURN: begin
            if (bus.ignition_end) begin
               if (k_q == 3'd1 || k_q == 3'd2) begin
                  state_d = S_SEP;
                  cnt_d   = SEP_LOAD;
               end else if (k_q == 3'd3) begin
                  state_d = S_COAST;
                  cnt_d   = COAST_LOAD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SEP: begin
            if (cnt_q == 32'd0) begin
               k_d     = k_q + 3'd1;
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_COAST: begin
            if (cnt_q == 32'd0) begin
               k_d     = 3'd4;
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: ;
      endcase

      // Abort overrides whatever the flight states decided this cycle; DONE stays terminal.
      if (bus.abort && (state_q == S_LOAD || state_q == S_BURN ||
                        state_q == S_SEP  || state_q == S_COAST)) begin
         state_d = S_ABORT;
         k_d     = k_q;
         cnt_d   = cnt_q;
      end

      if (state_d == S_LOAD) begin
         case (k_d)
            3'd1: begin
               isp_d = N'(SPECIFICIMPULSE_1);
               iw_d  = IW1;
               pw_d  = P1;
               bt_d  = N'(BURNTIME_1);
            end
            3'd2: begin
               isp_d = N'(SPECIFICIMPULSE_2);
               iw_d  = IW2;
               pw_d  = P2;
               bt_d  = N'(BURNTIME_2);
            end
            3'd3: begin
               isp_d = N'(SPECIFICIMPULSE_3);
               iw_d  = IW3;
               pw_d  = P3;
               bt_d  = N'(BURNTIME_3);
            end
            default: begin
               isp_d = N'(SPECIFICIMPULSE_3);
               iw_d  = IW4;
               pw_d  = P4;
               bt_d  = N'(BURNTIME_4);
            end
         endcase
      end
   end

   always_comb begin
      bus.specificImpulse  = isp_q;
      bus.initialWeight    = iw_q;
      bus.propellantWeight = pw_q;
      bus.burntime         = bt_q;
      bus.engine_resetb    = !(state_q == S_IDLE || state_q == S_LOAD || state_q == S_ABORT);
      bus.mission_done     = (state_q == S_DONE);
      bus.aborted          = (state_q == S_ABORT);
      // The counter still holds its load value only in the first SEP cycle.
      bus.stage_sep        = (state_q == S_SEP) && (cnt_q == SEP_LOAD);
      if (state_q == S_IDLE)
         bus.stage_state = 3'd0;
      else if (state_q == S_DONE || state_q == S_ABORT)
         bus.stage_state = 3'd7;
      else
         bus.stage_state = k_q;
   end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 64, the width of all mass/impulse/time outputs.
REQ-002 The module SHALL have parameter SPECIFICIMPULSE_1 / _2 / _3, defaults 363 / 421 / 421, the Isp for burns 1 / 2 / 3-4.
REQ-003 The module SHALL have parameter WEIGHT_PROPELLANT_1.._4, defaults 2077000 / 456100 / 39136 / 83864, the propellant mass per burn.
REQ-004 The module SHALL have parameter BURNTIME_1.._4, defaults 48 / 360 / 165 / 335, the burn duration per burn.
REQ-005 The module SHALL have parameter WEIGHT_STAGE_1.._3, defaults 137000 / 40100 / 15200, the dry mass per stage.
REQ-006 The module SHALL have parameter LM, default 15103, and parameter CMSM, default 11900, the payload masses.
REQ-007 The module SHALL have parameter SEP_CYCLES, default 4, the separation hold length; parameter COAST_CYCLES, default 8, the coast between burns 3 and 4.
REQ-008 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 The module SHALL have port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-010 The module SHALL have port start, input, 1 bit: level, begins the sequence from IDLE.
REQ-011 The module SHALL have port abort, input, 1 bit: level, forces ABORT.
REQ-012 The module SHALL have port ignition_end, input, 1 bit: burn-complete flag from the velocity integrator.
REQ-013 The module SHALL have port engine_resetb, output, 1 bit: active-low reset to the velocity integrator.
REQ-014 The module SHALL have outputs specificImpulse, initialWeight, propellantWeight and burntime, each N bits: the parameters of the current burn.
REQ-015 The module SHALL have output stage_state, 3 bits: 0 idle, 1-4 burn index, 7 done or abort.
REQ-016 The module SHALL have output stage_sep, 1 bit: one-cycle pulse at stage jettison.
REQ-017 The module SHALL have output mission_done, 1 bit: high in DONE.
REQ-018 The module SHALL have output aborted, 1 bit: high in ABORT.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, BURN, SEP, COAST, DONE and ABORT, with a 3-bit burn index k (1-4) and a 32-bit down-counter.
REQ-020 In IDLE with start=1, the FSM SHALL set k=1 and go to LOAD on the next edge.
REQ-021 LOAD SHALL last exactly one cycle and SHALL go to BURN.
REQ-022 engine_resetb SHALL be 0 in LOAD and IDLE and ABORT, and 1 in all other states.
REQ-023 The four parameter outputs SHALL be registered and SHALL update on the edge entering LOAD.
REQ-024 The four parameter outputs SHALL then hold stable through BURN, SEP and COAST.
REQ-025 initialWeight(k) SHALL be the sum of all propellant from burn k onward, plus the dry masses of all unjettisoned stages, plus LM, plus CMSM.
REQ-026 For burn 4, stage 3 dry mass SHALL still be counted.
REQ-027 All sums SHALL be constant-folded at elaboration in N-bit unsigned arithmetic; no runtime adders are used on this path.
REQ-028 In BURN, ignition_end=1 SHALL cause a transition on the next edge.
REQ-029 That BURN transition SHALL go to SEP when k is 1 or 2, to COAST when k is 3, and to DONE when k is 4.
REQ-030 ignition_end SHALL be ignored in every state other than BURN.
REQ-031 Entering SEP, the counter SHALL load SEP_CYCLES-1; stage_sep SHALL be high only in the first SEP cycle.
REQ-032 SEP SHALL count down to 0, then increment k and go to LOAD.
REQ-033 COAST SHALL load COAST_CYCLES-1, count down to 0, then set k=4 and go to LOAD; stage_sep SHALL stay 0 throughout COAST.
REQ-034 A SEP_CYCLES or COAST_CYCLES value of 0 SHALL be treated as 1.
REQ-035 stage_state SHALL equal k in LOAD, BURN, SEP and COAST, 0 in IDLE, and 7 in DONE and ABORT.
REQ-036 DONE and ABORT SHALL be terminal; only resetb leaves them.
REQ-037 abort=1 in any non-IDLE state SHALL cause ABORT on the next edge, with priority over ignition_end and counter expiry.
REQ-038 abort=1 in IDLE SHALL be ignored.
REQ-039 start SHALL be ignored outside IDLE.

Reset
REQ-040 On resetb=0, the block SHALL go immediately to IDLE regardless of clk, including mid-burn.
REQ-041 On reset, k, the counter, specificImpulse, initialWeight and propellantWeight SHALL all be 0.
REQ-042 On reset, burntime SHALL be 1, so the integrator never sees a zero divisor.
REQ-043 On reset, engine_resetb, stage_sep, mission_done, aborted and stage_state SHALL all be 0.

Verification
REQ-044 Scenario 1 SHALL be: reset release, then start=1 for one cycle. Required response: LOAD one cycle later with engine_resetb=0 for exactly 1 cycle; then BURN with initialWeight=2875403, specificImpulse=363, propellantWeight=2077000, burntime=48, stage_state=1.
REQ-045 Scenario 2 SHALL be: full nominal flight, with ignition_end pulsed 20 cycles into each BURN. Required response: initialWeight sequence 2875403, 661403, 165203, 126067; stage_sep pulses after burns 1 and 2 only, each SEP exactly 4 cycles; COAST exactly 8 cycles; mission_done=1, stage_state=7.
REQ-046 Scenario 3 SHALL be: ignition_end held high during SEP, COAST and IDLE. Required response: no state change.
REQ-047 Scenario 4 SHALL be: abort=1 asserted in the same cycle as ignition_end in BURN k=2. Required response: ABORT, aborted=1, engine_resetb=0, stage_state=7; start is ignored afterwards.
REQ-048 Scenario 5 SHALL be: resetb pulsed low mid-SEP, asynchronously between edges. Required response: outputs reach reset values before the next edge, with burntime=1.
REQ-049 Scenario 6 SHALL be: SEP_CYCLES=0, COAST_CYCLES=1. Required response: each SEP and COAST lasts 1 cycle, and stage_sep is still a single pulse.
